enc_velocity: RTL and testbench

Downstream consumer of the quadrature encoder position counter. Samples the 16-bit encoder count once per fixed window, forms a wrap-safe signed per-window delta, and outputs a moving average of the last 2^AVG_LOG2 deltas as a signed velocity in counts per window. It also latches the encoder fault flag until software clears it. Sits between the encoder counter and the motion-control/register-interface logic.

---
 rtl/enc_velocity.sv | 123 ++++++++++++
 tb/tb_enc_velocity.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/enc_velocity.sv
// Encoder velocity estimator: samples the position count once per window, forms a
// wrap-safe signed delta, and reports a moving average of the last 2^AVG_LOG2 deltas.
module enc_velocity #(
  parameter int WINDOW   = 1000,
  parameter int AVG_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] count,
  input  logic        faultn,
  input  logic        enable,
  input  logic        clear_fault,
  output logic [15:0] delta,
  output logic [15:0] velocity,
  output logic        vel_valid,
  output logic        fault_latched
);

  localparam int CW    = $clog2(WINDOW);
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = 16 + AVG_LOG2;
  localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t                  state_reg, state_next;
  logic [CW-1:0]           cnt_reg;
  logic [15:0]             prev_reg;
  logic                    pend_reg;
  logic [DEPTH-1:0][15:0]  hist_reg;
  logic [DEPTH-1:0][15:0]  hist_shift;
  logic signed [SW-1:0]    sum_reg;
  logic signed [SW-1:0]    sum_next;
  logic signed [SW-1:0]    delta_ext;
  logic signed [SW-1:0]    oldest_ext;
  logic signed [15:0]      avg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (enable) state_next = PRIME;
      PRIME:   state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = IDLE;
    endcase
    if (!enable) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // New delta enters at the head; the oldest entry drops off the tail.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hist
    if (gi == 0) begin : g_head
      assign hist_shift[gi] = delta;
    end else begin : g_tail
      assign hist_shift[gi] = hist_reg[gi-1];
    end
  end

  assign delta_ext  = SW'($signed(delta));
  assign oldest_ext = SW'($signed(hist_reg[DEPTH-1]));
  assign sum_next   = sum_reg + delta_ext - oldest_ext;
  assign avg        = 16'(sum_next >>> AVG_LOG2);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg       <= '0;
      prev_reg      <= '0;
      pend_reg      <= 1'b0;
      hist_reg      <= '0;
      sum_reg       <= '0;
      delta         <= '0;
      velocity      <= '0;
      vel_valid     <= 1'b0;
      fault_latched <= 1'b0;
    end else begin
      // Set has priority over a simultaneous clear.
      if (!faultn)          fault_latched <= 1'b1;
      else if (clear_fault) fault_latched <= 1'b0;

      vel_valid <= 1'b0;

      if (!enable) begin
        cnt_reg  <= '0;
        pend_reg <= 1'b0;
        hist_reg <= '0;
        sum_reg  <= '0;
        delta    <= '0;
        velocity <= '0;
      end else begin
        case (state_reg)
          PRIME: begin
            prev_reg <= count;
            cnt_reg  <= '0;
            pend_reg <= 1'b0;
          end
          RUN: begin
            if (cnt_reg == LAST) begin
              cnt_reg  <= '0;
              delta    <= count - prev_reg;
              prev_reg <= count;
              pend_reg <= 1'b1;
            end else begin
              cnt_reg  <= cnt_reg + CW'(1);
              pend_reg <= 1'b0;
            end
            if (pend_reg) begin
              sum_reg   <= sum_next;
              hist_reg  <= hist_shift;
              velocity  <= avg;
              vel_valid <= 1'b1;
            end
          end
          default: pend_reg <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_enc_velocity.sv
// Directed self-checking bench for enc_velocity with WINDOW=8, AVG_LOG2=2.
module tb_enc_velocity;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] count;
  logic        faultn;
  logic        enable;
  logic        clear_fault;
  logic [15:0] delta;
  logic [15:0] velocity;
  logic        vel_valid;
  logic        fault_latched;

  int total = 0;
  int bad   = 0;
  int n;
  logic seen;
  logic [15:0] exp_vel [5] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd3};

  enc_velocity #(.WINDOW(8), .AVG_LOG2(2)) dut (
    .clk(clk), .reset(reset), .count(count), .faultn(faultn), .enable(enable),
    .clear_fault(clear_fault), .delta(delta), .velocity(velocity),
    .vel_valid(vel_valid), .fault_latched(fault_latched)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Steps until vel_valid is seen; returns the step count, or -1 on timeout.
  task automatic wait_valid(output int steps);
    steps = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (vel_valid) begin
        steps = i;
        break;
      end
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; count = 16'd100; faultn = 1'b1; clear_fault = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();
    check("rst_delta", 32'(delta), 32'd0);
    check("rst_velocity", 32'(velocity), 32'd0);
    check("rst_vel_valid", 32'(vel_valid), 32'd0);
    check("rst_fault", 32'(fault_latched), 32'd0);

    // Constant count: first strobe WINDOW+2 edges after the enable edge.
    enable = 1'b1;
    wait_valid(n);
    check("t1_first_latency", 32'(n), 32'd11);
    check("t1_delta", 32'(delta), 32'd0);
    check("t1_velocity", 32'(velocity), 32'd0);
    wait_valid(n);
    check("t1_period", 32'(n), 32'd8);

    // +3 per window: averages ramp 0,1,2,3 then hold at 3.
    for (int i = 0; i < 5; i++) begin
      count = count + 16'd3;
      wait_valid(n);
      check($sformatf("t2_period_%0d", i), 32'(n), 32'd8);
      check($sformatf("t2_delta_%0d", i), 32'(delta), 32'd3);
      check($sformatf("t2_velocity_%0d", i), 32'(velocity), 32'(exp_vel[i]));
    end
    step();
    check("t2_valid_fall", 32'(vel_valid), 32'd0);

    // Fault set / hold / clear / set-wins while the window keeps running.
    faultn = 1'b0;
    step();
    faultn = 1'b1;
    check("t4_fault_set", 32'(fault_latched), 32'd1);
    step();
    check("t4_fault_hold", 32'(fault_latched), 32'd1);
    clear_fault = 1'b1;
    step();
    clear_fault = 1'b0;
    check("t4_fault_clear", 32'(fault_latched), 32'd0);
    faultn = 1'b0; clear_fault = 1'b1;
    step();
    faultn = 1'b1; clear_fault = 1'b0;
    check("t4_fault_set_wins", 32'(fault_latched), 32'd1);
    wait_valid(n);
    check("t4_period", 32'(n), 32'd3);
    check("t4_delta", 32'(delta), 32'd0);
    check("t4_velocity", 32'(velocity), 32'd2);

    // Drop enable mid-window.
    repeat (3) step();
    enable = 1'b0;
    step();
    check("t5_delta", 32'(delta), 32'd0);
    check("t5_velocity", 32'(velocity), 32'd0);
    check("t5_vel_valid", 32'(vel_valid), 32'd0);
    check("t5_fault_kept", 32'(fault_latched), 32'd1);
    seen = 1'b0;
    repeat (12) begin
      step();
      if (vel_valid) seen = 1'b1;
    end
    check("t5_no_valid_idle", 32'(seen), 32'd0);
    clear_fault = 1'b1;
    step();
    clear_fault = 1'b0;
    check("t5_fault_clear", 32'(fault_latched), 32'd0);

    // Wrap upward: 0xFFFE -> 0x0003 is +5.
    count = 16'hFFFE; enable = 1'b1;
    step();
    step();
    count = 16'h0003;
    wait_valid(n);
    check("t3_up_latency", 32'(n), 32'd9);
    check("t3_up_delta", 32'(delta), 32'h0005);
    check("t3_up_velocity", 32'(velocity), 32'd1);

    // Wrap downward from fresh history: 0x0002 -> 0xFFFD is -5, average -2.
    enable = 1'b0;
    step();
    count = 16'h0002; enable = 1'b1;
    step();
    step();
    count = 16'hFFFD;
    wait_valid(n);
    check("t3_dn_latency", 32'(n), 32'd9);
    check("t3_dn_delta", 32'(delta), 32'hFFFB);
    check("t3_dn_velocity", 32'(velocity), 32'hFFFE);

    // Reset at counter=5 with a nonzero sum and a latched fault.
    faultn = 1'b0;
    step();
    faultn = 1'b1;
    check("t6_fault_pre", 32'(fault_latched), 32'd1);
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_delta", 32'(delta), 32'd0);
    check("t6_velocity", 32'(velocity), 32'd0);
    check("t6_vel_valid", 32'(vel_valid), 32'd0);
    check("t6_fault", 32'(fault_latched), 32'd0);
    wait_valid(n);
    check("t6_reprime_latency", 32'(n), 32'd11);
    check("t6_delta_after", 32'(delta), 32'd0);
    check("t6_velocity_after", 32'(velocity), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
